// File: rtl/pipe_muladd_pkg.sv
// pipe_muladd_pkg: shared divider/multiply-add widths so both sides of a round trip agree
package pipe_muladd_pkg;
  localparam int DEND_W = 16;
  localparam int SOR_W = 10;
  localparam int ACC_W = DEND_W + SOR_W;
endpackage

// File: rtl/pipe_muladd_if.sv
// pipe_muladd_if: input triple and reconstructed-dividend result of pipe_muladd
interface pipe_muladd_if
  import pipe_muladd_pkg::*;
#(
  parameter int DEND_W_P = DEND_W,
  parameter int SOR_W_P = SOR_W
);
  logic                        valid_i;
  logic [DEND_W_P-1:0]         quotient_i;
  logic [SOR_W_P-1:0]          divisor_i;
  logic [SOR_W_P-1:0]          remainder_i;
  logic                        valid_o;
  logic [DEND_W_P+SOR_W_P-1:0] dividend_o;
  logic                        err_o;
  modport master (output valid_i, quotient_i, divisor_i, remainder_i, input valid_o, dividend_o, err_o);
  modport slave (input valid_i, quotient_i, divisor_i, remainder_i, output valid_o, dividend_o, err_o);
endinterface

// File: rtl/pipe_muladd_stage.sv
// pipe_muladd_stage: one shift-add step, adding quotient<<K when divisor bit K is set
module pipe_muladd_stage #(
  parameter int K = 0,
  parameter int DEND_W = 16,
  parameter int SOR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [DEND_W-1:0]       i_quot,
  input  logic [SOR_W-1:0]        i_div,
  input  logic [DEND_W+SOR_W-1:0] i_acc,
  input  logic                    i_err,
  output logic                    o_valid,
  output logic [DEND_W-1:0]       o_quot,
  output logic [SOR_W-1:0]        o_div,
  output logic [DEND_W+SOR_W-1:0] o_acc,
  output logic                    o_err
);
  localparam int ACC_W = DEND_W + SOR_W;
  logic [ACC_W-1:0] w_add;
  assign w_add = i_div[K] ? ACC_W'(i_quot) << K : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_quot  <= '0;
      o_div   <= '0;
      o_acc   <= '0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_quot  <= i_quot;
      o_div   <= i_div;
      o_acc   <= i_acc + w_add;
      o_err   <= i_err;
    end
  end
endmodule

// File: rtl/pipe_muladd.sv
// pipe_muladd: pipelined quotient*divisor+remainder, one divisor bit per stage,
// flagging triples that no divider could have produced
module pipe_muladd
  import pipe_muladd_pkg::*;
#(
  parameter int DEND_W_P = DEND_W,
  parameter int SOR_W_P = SOR_W
) (
  input logic clk,
  input logic rst_n,
  pipe_muladd_if.slave bus
);
  localparam int AW = DEND_W_P + SOR_W_P;
  logic                w_valid [SOR_W_P+1];
  logic [DEND_W_P-1:0] w_quot  [SOR_W_P+1];
  logic [SOR_W_P-1:0]  w_div   [SOR_W_P+1];
  logic [AW-1:0]       w_acc   [SOR_W_P+1];
  logic                w_err   [SOR_W_P+1];
  assign w_valid[0] = bus.valid_i;
  assign w_quot[0]  = bus.quotient_i;
  assign w_div[0]   = bus.divisor_i;
  assign w_acc[0]   = AW'(bus.remainder_i);
  assign w_err[0]   = (bus.divisor_i == '0) || (bus.remainder_i >= bus.divisor_i);
  for (genvar k = 0; k < SOR_W_P; k++) begin : g_stage
    pipe_muladd_stage #(.K(k), .DEND_W(DEND_W_P), .SOR_W(SOR_W_P)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_valid[k]),
      .i_quot  (w_quot[k]),
      .i_div   (w_div[k]),
      .i_acc   (w_acc[k]),
      .i_err   (w_err[k]),
      .o_valid (w_valid[k+1]),
      .o_quot  (w_quot[k+1]),
      .o_div   (w_div[k+1]),
      .o_acc   (w_acc[k+1]),
      .o_err   (w_err[k+1])
    );
  end
  assign bus.valid_o    = w_valid[SOR_W_P];
  assign bus.dividend_o = w_acc[SOR_W_P];
  assign bus.err_o      = w_err[SOR_W_P];
endmodule

// File: tb/tb_pipe_muladd.sv
// tb_pipe_muladd: directed vectors with hand-computed results plus a divide/reconstruct round trip
module tb_pipe_muladd;
  import pipe_muladd_pkg::*;
  typedef struct {
    logic        v;
    logic [31:0] dd;
    logic        e;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  pipe_muladd_if bus ();
  pipe_muladd dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic prefill();
    exp_t b;
    sb.delete();
    b.v = 1'b0;
    b.dd = '0;
    b.e = 1'b0;
    for (int i = 0; i < SOR_W - 1; i++) sb.push_back(b);
  endtask
  task automatic cyc(input string tag, input logic v, input logic [15:0] q, input logic [9:0] d,
                     input logic [9:0] r, input logic [31:0] dd, input logic e);
    exp_t x, o;
    bus.valid_i = v;
    bus.quotient_i = q;
    bus.divisor_i = d;
    bus.remainder_i = r;
    x.v = v;
    x.dd = dd;
    x.e = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == SOR_W) begin
      o = sb.pop_front();
      chk({tag, ".valid"}, 32'(bus.valid_o), 32'(o.v));
      if (o.v) begin
        chk({tag, ".dividend"}, 32'(bus.dividend_o), o.dd);
        chk({tag, ".err"}, 32'(bus.err_o), 32'(o.e));
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 1'b0, 16'd0, 10'd0, 10'd0, 32'd0, 1'b0);
  endtask
  initial begin
    logic [15:0] dend;
    logic [9:0] dsor;
    bus.valid_i = 1'b0;
    bus.quotient_i = '0;
    bus.divisor_i = '0;
    bus.remainder_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(bus.valid_o), 32'd0);
    chk("rst.dividend", 32'(bus.dividend_o), 32'd0);
    chk("rst.err", 32'(bus.err_o), 32'd0);
    #2 rst_n = 1'b1;
    prefill();
    cyc("carry", 1'b1, 16'd21845, 10'd3, 10'd1, 32'd65536, 1'b0);
    cyc("max", 1'b1, 16'd65535, 10'd1023, 10'd1022, 32'd67043327, 1'b0);
    cyc("div0", 1'b1, 16'd5, 10'd0, 10'd0, 32'd0, 1'b1);
    cyc("rem_eq", 1'b1, 16'd1, 10'd7, 10'd7, 32'd14, 1'b1);
    idle(3);
    cyc("pat0", 1'b1, 16'd100, 10'd5, 10'd3, 32'd503, 1'b0);
    cyc("pat1", 1'b1, 16'd7, 10'd9, 10'd2, 32'd65, 1'b0);
    cyc("pat2", 1'b0, 16'd1, 10'd1, 10'd0, 32'd0, 1'b0);
    cyc("pat3", 1'b1, 16'd300, 10'd20, 10'd19, 32'd6019, 1'b0);
    cyc("pat4", 1'b0, 16'd2, 10'd2, 10'd0, 32'd0, 1'b0);
    cyc("pat5", 1'b0, 16'd3, 10'd3, 10'd0, 32'd0, 1'b0);
    cyc("pat6", 1'b1, 16'd1000, 10'd1000, 10'd999, 32'd1000999, 1'b0);
    idle(SOR_W);
    for (int i = 0; i < 5; i++) cyc("inflight", 1'b1, 16'(i + 1), 10'd3, 10'd0, 32'(3 * (i + 1)), 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("midrst.valid_now", 32'(bus.valid_o), 32'd0);
    bus.valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk("midrst.valid_hold", 32'(bus.valid_o), 32'd0);
    end
    #2 rst_n = 1'b1;
    prefill();
    idle(4);
    cyc("post_rst", 1'b1, 16'd12, 10'd11, 10'd10, 32'd142, 1'b0);
    idle(SOR_W);
    dend = '0;
    dsor = '0;
    for (int i = 0; i < 2100; i++) begin
      if (dsor == '0) cyc("trip_bubble", 1'b0, 16'd0, 10'd0, 10'd0, 32'd0, 1'b0);
      else cyc("trip", 1'b1, 16'(dend / 16'(dsor)), dsor, 10'(dend % 16'(dsor)), 32'(dend), 1'b0);
      dend = dend + 16'd3;
      dsor = dsor + 10'd2;
    end
    idle(SOR_W);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
